bit_serial_alu_ctrl: RTL and testbench

//   Sequential controller that drives the 1-bit logic/arith slice datapath.
//   It accepts WIDTH-bit operand pairs through a valid/ready handshake and

---
 rtl/bit_serial_alu_ctrl.sv | 142 ++++++++++++++
 tb/tb_bit_serial_alu_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU controller: accepts WIDTH-bit operand pairs, runs them LSB-first
// through a 1-bit AND/OR/NAND/ADD slice, and hands the result word downstream.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b11;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             zero_q, zero_d;

  logic             slice_s;
  logic             slice_c;
  logic             last_bit;

  assign last_bit = (cnt_q == LAST_BIT);

  // The 1-bit slice; the carry only advances for ADD.
  always_comb begin
    slice_s = 1'b0;
    slice_c = carry_q;
    unique case (op_q)
      OP_AND:  slice_s = a_sh_q[0] & b_sh_q[0];
      OP_OR:   slice_s = a_sh_q[0] | b_sh_q[0];
      OP_NAND: slice_s = ~(a_sh_q[0] & b_sh_q[0]);
      OP_ADD: begin
        slice_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        slice_c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
      end
      default: slice_s = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: load on accept, shift one bit per RUN cycle, flags on the last bit.
  always_comb begin
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    op_d        = op_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        result_d = {slice_s, result_q[WIDTH-1:1]};
        carry_d  = slice_c;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) begin
          carry_out_d = (op_q == OP_ADD) ? slice_c : 1'b0;
          zero_d      = (result_d == '0);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
    carry_out = carry_out_q;
    zero      = zero_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      op_q        <= OP_AND;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed self-checking bench for bit_serial_alu_ctrl at WIDTH=8.
module tb_bit_serial_alu_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;

  int vectors;
  int miscompares;

  bit_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      tick();
      cycles++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    tick();
    tick();
    vectors++;
    if (out_valid !== 1'b0 || result !== 8'h00 || carry_out !== 1'b0 || zero !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got v=%b r=%h c=%b z=%b expected v=0 r=00 c=0 z=0",
               out_valid, result, carry_out, zero);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_and_timing();
    int cyc;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL and_idle_ready: got %b expected 1", in_ready);
    end
    issue(2'b00, 8'hF0, 8'h3C);
    op = 2'b11;
    a = 8'h00;
    b = 8'hFF;
    wait_done(cyc);
    vectors++;
    if (cyc !== WIDTH || out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL and_latency: got %0d cycles valid=%b expected %0d cycles valid=1",
               cyc, out_valid, WIDTH);
    end
    vectors++;
    if (result !== 8'h30 || carry_out !== 1'b0 || zero !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL and_result: got r=%h c=%b z=%b expected r=30 c=0 z=0",
               result, carry_out, zero);
    end
    pop();
  endtask

  task automatic test_add();
    int cyc;
    issue(2'b11, 8'hFF, 8'h01);
    wait_done(cyc);
    vectors++;
    if (out_valid !== 1'b1 || result !== 8'h00 || carry_out !== 1'b1 || zero !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL add_ff_01: got v=%b r=%h c=%b z=%b expected v=1 r=00 c=1 z=1",
               out_valid, result, carry_out, zero);
    end
    pop();
    issue(2'b11, 8'h5A, 8'h25);
    wait_done(cyc);
    vectors++;
    if (out_valid !== 1'b1 || result !== 8'h7F || carry_out !== 1'b0 || zero !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL add_5a_25: got v=%b r=%h c=%b z=%b expected v=1 r=7f c=0 z=0",
               out_valid, result, carry_out, zero);
    end
    pop();
  endtask

  task automatic test_logic();
    int cyc;
    issue(2'b10, 8'h00, 8'h00);
    wait_done(cyc);
    vectors++;
    if (out_valid !== 1'b1 || result !== 8'hFF || carry_out !== 1'b0 || zero !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL nand_00_00: got v=%b r=%h c=%b z=%b expected v=1 r=ff c=0 z=0",
               out_valid, result, carry_out, zero);
    end
    pop();
    issue(2'b01, 8'h00, 8'h00);
    wait_done(cyc);
    vectors++;
    if (out_valid !== 1'b1 || result !== 8'h00 || carry_out !== 1'b0 || zero !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL or_00_00: got v=%b r=%h c=%b z=%b expected v=1 r=00 c=0 z=1",
               out_valid, result, carry_out, zero);
    end
    pop();
    issue(2'b01, 8'hA5, 8'h0F);
    wait_done(cyc);
    vectors++;
    if (out_valid !== 1'b1 || result !== 8'hAF || carry_out !== 1'b0 || zero !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL or_a5_0f: got v=%b r=%h c=%b z=%b expected v=1 r=af c=0 z=0",
               out_valid, result, carry_out, zero);
    end
    pop();
  endtask

  task automatic test_hold();
    int cyc;
    int bad_valid;
    int bad_result;
    int bad_ready;
    bad_valid = 0;
    bad_result = 0;
    bad_ready = 0;
    issue(2'b11, 8'h80, 8'h80);
    wait_done(cyc);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      a = 8'h11;
      b = 8'h22;
      if (out_valid !== 1'b1) bad_valid++;
      if (result !== 8'h00 || carry_out !== 1'b1 || zero !== 1'b1) bad_result++;
      if (in_ready !== 1'b0) bad_ready++;
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (bad_valid != 0) begin
      miscompares++;
      $display("[TB] FAIL hold_valid: got %0d cycles without out_valid expected 0", bad_valid);
    end
    vectors++;
    if (bad_result != 0) begin
      miscompares++;
      $display("[TB] FAIL hold_result: got %0d cycles with changed r/c/z expected 0 (r=%h c=%b z=%b)",
               bad_result, result, carry_out, zero);
    end
    vectors++;
    if (bad_ready != 0) begin
      miscompares++;
      $display("[TB] FAIL hold_in_ready: got %0d cycles with in_ready=1 expected 0", bad_ready);
    end
    pop();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_release: got in_ready=%b out_valid=%b expected 1 and 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int pulses;
    pulses = 0;
    issue(2'b11, 8'hF0, 8'h0F);
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 8'h00 || carry_out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset: got rdy=%b v=%b r=%h c=%b expected rdy=1 v=0 r=00 c=0",
               in_ready, out_valid, result, carry_out);
    end
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) pulses++;
      tick();
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("[TB] FAIL midrun_no_pulse: got %0d out_valid cycles expected 0", pulses);
    end
    issue(2'b11, 8'h03, 8'h04);
    wait_done(cyc);
    vectors++;
    if (out_valid !== 1'b1 || result !== 8'h07 || carry_out !== 1'b0 || zero !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL after_reset_add: got v=%b r=%h c=%b z=%b expected v=1 r=07 c=0 z=0",
               out_valid, result, carry_out, zero);
    end
    pop();
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops   [4];
    logic [7:0] as    [4];
    logic [7:0] bs    [4];
    logic [7:0] exp_r [4];
    logic       exp_c [4];
    int         acc_cyc [4];
    int         acc_idx;
    int         res_idx;
    int         cyc;
    ops[0] = 2'b11; as[0] = 8'hC8; bs[0] = 8'h4B; exp_r[0] = 8'h13; exp_c[0] = 1'b1;
    ops[1] = 2'b10; as[1] = 8'hAA; bs[1] = 8'h0F; exp_r[1] = 8'hF5; exp_c[1] = 1'b0;
    ops[2] = 2'b01; as[2] = 8'h81; bs[2] = 8'h18; exp_r[2] = 8'h99; exp_c[2] = 1'b0;
    ops[3] = 2'b00; as[3] = 8'hFF; bs[3] = 8'hFF; exp_r[3] = 8'hFF; exp_c[3] = 1'b0;
    acc_idx = 0;
    res_idx = 0;
    cyc = 0;
    out_ready = 1'b1;
    while (res_idx < 4 && cyc < 200) begin
      if (out_valid === 1'b1) begin
        vectors++;
        if (result !== exp_r[res_idx] || carry_out !== exp_c[res_idx]) begin
          miscompares++;
          $display("[TB] FAIL b2b_result%0d: got r=%h c=%b expected r=%h c=%b",
                   res_idx, result, carry_out, exp_r[res_idx], exp_c[res_idx]);
        end
        res_idx++;
      end
      if (in_ready === 1'b1) begin
        if (acc_idx < 4) begin
          op = ops[acc_idx];
          a = as[acc_idx];
          b = bs[acc_idx];
          in_valid = 1'b1;
          acc_cyc[acc_idx] = cyc;
          acc_idx++;
        end else begin
          in_valid = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (res_idx != 4) begin
      miscompares++;
      $display("[TB] FAIL b2b_complete: got %0d results expected 4", res_idx);
    end
    for (int i = 1; i < 4; i++) begin
      if (i < acc_idx) begin
        vectors++;
        if (acc_cyc[i] - acc_cyc[i-1] != WIDTH + 2) begin
          miscompares++;
          $display("[TB] FAIL b2b_spacing%0d: got %0d cycles expected %0d",
                   i, acc_cyc[i] - acc_cyc[i-1], WIDTH + 2);
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_and_timing();
    test_add();
    test_logic();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
